ov5640_power_seq: RTL and testbench
===================================

// Module: ov5640_power_seq
// PURPOSE
//  Drives the OV5640 power-up sequence: PWDN high, then RESETB low, then a settle period.
//  Also gates the camera XCLK source.
//  It sits upstream of the camera top, SCCB configuration and the 24 MHz clock generator.
//  It replaces the free-running counters in the top level with one state machine.
//  power_done is the release signal for the SCCB configuration logic.
// PARAMETERS
//  CNT_PWDN    300_000    sys_clk cycles PWDN is held high with XCLK running (6 ms @ 50 MHz)
//  CNT_RST     100_000    sys_clk cycles RESETB is held low after PWDN release (2 ms)
//  CNT_SETTLE  1_050_000  sys_clk cycles after RESETB release before power_done (21 ms)
//  CNT_W       21         phase counter width; must hold max(CNT_*)-1
// PORTS
//  sys_clk       in   1  system clock, 50 MHz
//  sys_rst       in   1  asynchronous reset, active-high
//  pwr_en        in   1  asynchronous power request (switch); level-sensitive
//  ov5640_pwdn   out  1  camera power-down; 1 = powered down
//  ov5640_rst_n  out  1  camera RESETB, active-low
//  xclk_en       out  1  enable for the XCLK clock generator; 1 = clock running
//  power_done    out  1  camera ready for SCCB access
//  seq_state     out  3  current state, for debug and LEDs
// BEHAVIOUR
//  - Reset (sys_rst=1, asynchronous) forces the following, independent of sys_clk:
//      state=OFF, cnt=0, sync flops=0;
//      ov5640_pwdn=1, ov5640_rst_n=0, xclk_en=0, power_done=0, seq_state=0.
//  - pwr_en passes through a 2-FF synchronizer to give pwr_en_s.
//  - All outputs are registered decodes of the next state.
//    They change on the same edge as the state register; there is no glitch path.
//  - States and their output values:
//      OFF    = 3'd0  pwdn=1 rst_n=0 xclk_en=0 done=0
//      PWDN   = 3'd1  pwdn=1 rst_n=0 xclk_en=1 done=0
//      RST    = 3'd2  pwdn=0 rst_n=0 xclk_en=1 done=0
//      SETTLE = 3'd3  pwdn=0 rst_n=1 xclk_en=1 done=0
//      DONE   = 3'd4  pwdn=0 rst_n=1 xclk_en=1 done=1
//      Codes 5-7 are illegal and recover to OFF on the next edge.
//  - Transitions, evaluated in priority order every sys_clk edge:
//      1. pwr_en_s=0 in any state -> OFF, cnt=0. This overrides expiry on the same edge.
//      2. OFF and pwr_en_s=1 -> PWDN, cnt=0.
//      3. PWDN and cnt==CNT_PWDN-1 -> RST, cnt=0; otherwise cnt+1.
//      4. RST and cnt==CNT_RST-1 -> SETTLE, cnt=0; otherwise cnt+1.
//      5. SETTLE and cnt==CNT_SETTLE-1 -> DONE, cnt=0; otherwise cnt+1.
//      6. DONE holds and cnt holds 0.
//  - Each phase therefore lasts exactly CNT_x cycles in its state.
//    Example: ov5640_pwdn stays high for exactly CNT_PWDN cycles after xclk_en rises.
//  - Latency: a pwr_en rise is sampled at edge k.
//    pwr_en_s=1 after edge k+1; state=PWDN and xclk_en=1 after edge k+2.
//  - Power drop: a pwr_en fall reaches OFF 2 edges after sampling, from any state including DONE.
//  - Re-request restarts the full sequence from PWDN; no phase is shortened.
//  - The counter never wraps. It is cleared on every state change and is compared only within its phase.
//  - The counter arithmetic is unsigned, CNT_W bits.
//    Parameter check: each CNT_x must be >= 1 and <= 2**CNT_W.
//    Elaboration fails on a violation.
// STRUCTURE
//  - Shared package ov5640_pkg holds:
//      state encodings OFF/PWDN/RST/SETTLE/DONE (3-bit);
//      default CNT_PWDN/CNT_RST/CNT_SETTLE constants;
//      CNT_W.
//  - Sub-module sync_2ff (1-bit, asynchronous active-high reset to 0) synchronizes pwr_en.
//  - The body holds the state register, the phase counter and the registered output decode.
// TESTING (bench overrides CNT_PWDN=6, CNT_RST=2, CNT_SETTLE=21, CNT_W=5)
//  1. Assert sys_rst with pwr_en=1 -> outputs stay pwdn=1 rst_n=0 xclk_en=0 done=0 state=0.
//     Release sys_rst -> PWDN 2 edges later.
//  2. Nominal run:
//     - pwr_en held at 1;
//     - xclk_en rises, then pwdn falls exactly 6 edges later;
//     - rst_n rises 2 edges after that;
//     - power_done rises 21 edges after that.
//     Total 29 edges from xclk_en to power_done.
//  3. Drop pwr_en in SETTLE at cnt=10 -> OFF with all outputs at reset values 2 edges later.
//     Re-assert -> full 6/2/21 sequence restarts.
//  4. Drop pwr_en on the edge where PWDN cnt==5 (expiry) -> state goes OFF, not RST; pwdn stays 1.
//  5. Assert sys_rst asynchronously mid-RST (between edges) -> outputs hit reset values before the next edge.
//     Release -> sequence restarts.
//  6. Force seq_state to 3'd6 -> OFF on the next edge.
//     Hold pwr_en=1 in DONE for 1000 edges -> outputs stable, cnt=0.

Source files
------------

// File: rtl/ov5640_pkg.sv
// Shared types and defaults for the OV5640 power-up sequencer.
// Holds state encodings, phase lengths, counter width and the output decode.
package ov5640_pkg;

  typedef enum logic [2:0] {
    ST_OFF    = 3'd0,
    ST_PWDN   = 3'd1,
    ST_RST    = 3'd2,
    ST_SETTLE = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  localparam int CNT_PWDN_DEF   = 300_000;
  localparam int CNT_RST_DEF    = 100_000;
  localparam int CNT_SETTLE_DEF = 1_050_000;
  localparam int CNT_W_DEF      = 21;

  typedef struct packed {
    logic pwdn;
    logic rst_n;
    logic xclk_en;
    logic done;
  } pwr_out_t;

  // Illegal codes decode to the safe OFF values.
  function automatic pwr_out_t decode(logic [2:0] s);
    pwr_out_t o;
    o = '{pwdn: 1'b1, rst_n: 1'b0, xclk_en: 1'b0, done: 1'b0};
    case (s)
      ST_PWDN:   o = '{1'b1, 1'b0, 1'b1, 1'b0};
      ST_RST:    o = '{1'b0, 1'b0, 1'b1, 1'b0};
      ST_SETTLE: o = '{1'b0, 1'b1, 1'b1, 1'b0};
      ST_DONE:   o = '{1'b0, 1'b1, 1'b1, 1'b1};
      default:   o = '{1'b1, 1'b0, 1'b0, 1'b0};
    endcase
    return o;
  endfunction

endpackage

// File: rtl/ov5640_power_seq_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level.
// Ports: clk_i, rst_i (async, active-high, clears to 0), d_i, q_o.
module sync_2ff (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/ov5640_power_seq.sv
// OV5640 power-up sequencer: PWDN phase, RESETB phase, settle, then done.
// Ports: sys_clk, sys_rst (async high), pwr_en (async level) in;
//        ov5640_pwdn, ov5640_rst_n, xclk_en, power_done, seq_state[2:0] out.
module ov5640_power_seq
  import ov5640_pkg::*;
#(
  parameter int CNT_PWDN   = CNT_PWDN_DEF,
  parameter int CNT_RST    = CNT_RST_DEF,
  parameter int CNT_SETTLE = CNT_SETTLE_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       pwr_en,
  output logic       ov5640_pwdn,
  output logic       ov5640_rst_n,
  output logic       xclk_en,
  output logic       power_done,
  output logic [2:0] seq_state
);

  localparam longint CNT_MAX = longint'(1) << CNT_W;

  if (CNT_PWDN < 1 || longint'(CNT_PWDN) > CNT_MAX ||
      CNT_RST < 1 || longint'(CNT_RST) > CNT_MAX ||
      CNT_SETTLE < 1 || longint'(CNT_SETTLE) > CNT_MAX) begin : g_bad_param
    $error("ov5640_power_seq: phase length out of range for CNT_W");
  end

  localparam logic [CNT_W-1:0] PWDN_LAST   = CNT_W'(CNT_PWDN - 1);
  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(CNT_RST - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(CNT_SETTLE - 1);

  logic             pwr_en_s;
  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  pwr_out_t         out_q;

  sync_2ff u_sync (
    .clk_i (sys_clk),
    .rst_i (sys_rst),
    .d_i   (pwr_en),
    .q_o   (pwr_en_s)
  );

  // Counter is zero on every state change, so each phase
  // lasts exactly its CNT_x edges.
  always_comb begin
    state_d = ST_OFF;
    cnt_d   = '0;
    if (pwr_en_s) begin
      case (state_q)
        ST_OFF: state_d = ST_PWDN;
        ST_PWDN: begin
          if (cnt_q == PWDN_LAST) begin
            state_d = ST_RST;
          end else begin
            state_d = ST_PWDN;
            cnt_d   = cnt_q + 1'b1;
          end
        end
        ST_RST: begin
          if (cnt_q == RST_LAST) begin
            state_d = ST_SETTLE;
          end else begin
            state_d = ST_RST;
            cnt_d   = cnt_q + 1'b1;
          end
        end
        ST_SETTLE: begin
          if (cnt_q == SETTLE_LAST) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_SETTLE;
            cnt_d   = cnt_q + 1'b1;
          end
        end
        ST_DONE: state_d = ST_DONE;
        default: state_d = ST_OFF;
      endcase
    end
  end

  // Outputs decode the next state so they switch with the state register.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= ST_OFF;
      cnt_q   <= '0;
      out_q   <= decode(ST_OFF);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= decode(state_d);
    end
  end

  assign ov5640_pwdn  = out_q.pwdn;
  assign ov5640_rst_n = out_q.rst_n;
  assign xclk_en      = out_q.xclk_en;
  assign power_done   = out_q.done;
  assign seq_state    = state_q;

endmodule

// File: tb/tb_ov5640_power_seq.sv
// Directed bench for ov5640_power_seq with short phases (6/2/21).
// Expected state/output vectors are queued and popped at each check point.
module tb_ov5640_power_seq;

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic       pwr_en;
  logic       ov5640_pwdn;
  logic       ov5640_rst_n;
  logic       xclk_en;
  logic       power_done;
  logic [2:0] seq_state;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string      tag;
    logic [6:0] v;
  } exp_t;

  exp_t sb[$];

  always #5 sys_clk = ~sys_clk;

  ov5640_power_seq #(
    .CNT_PWDN   (6),
    .CNT_RST    (2),
    .CNT_SETTLE (21),
    .CNT_W      (5)
  ) dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .pwr_en       (pwr_en),
    .ov5640_pwdn  (ov5640_pwdn),
    .ov5640_rst_n (ov5640_rst_n),
    .xclk_en      (xclk_en),
    .power_done   (power_done),
    .seq_state    (seq_state)
  );

  // {state, pwdn, rst_n, xclk_en, done}
  function automatic logic [6:0] vec(logic [2:0] st);
    logic [3:0] o;
    case (st)
      3'd1:    o = 4'b1010;
      3'd2:    o = 4'b0010;
      3'd3:    o = 4'b0110;
      3'd4:    o = 4'b0111;
      default: o = 4'b1000;
    endcase
    return {st, o};
  endfunction

  function automatic logic [6:0] observed();
    return {seq_state, ov5640_pwdn, ov5640_rst_n,
            xclk_en, power_done};
  endfunction

  task automatic push(string tag, logic [2:0] st);
    exp_t e;
    e.tag = tag;
    e.v   = vec(st);
    sb.push_back(e);
  endtask

  task automatic check();
    exp_t       e;
    logic [6:0] obs;
    obs = observed();
    e   = sb.pop_front();
    n_tests++;
    assert (obs === e.v) else begin
      n_fail++;
      $error("FAIL %s: got %b expected %b", e.tag, obs, e.v);
    end
  endtask

  task automatic expect_st(string tag, logic [2:0] st);
    push(tag, st);
    check();
  endtask

  task automatic check_cnt(string tag, logic [4:0] exp);
    n_tests++;
    assert (dut.cnt_q === exp) else begin
      n_fail++;
      $error("FAIL %s: cnt got %0d expected %0d", tag, dut.cnt_q, exp);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  // Call right after the edge that entered PWDN.
  task automatic run_seq(string tag);
    logic [2:0] st;
    for (int i = 1; i <= 29; i++) begin
      tick(1);
      if (i < 6)       st = 3'd1;
      else if (i < 8)  st = 3'd2;
      else if (i < 29) st = 3'd3;
      else             st = 3'd4;
      expect_st($sformatf("%s_e%0d", tag, i), st);
    end
  endtask

  initial begin
    int bad;

    // 1: reset held with pwr_en high
    sys_rst = 1'b1;
    pwr_en  = 1'b1;
    #2;
    expect_st("rst_async", 3'd0);
    tick(3);
    expect_st("rst_hold", 3'd0);
    check_cnt("rst_cnt", 5'd0);
    sys_rst = 1'b0;
    tick(1);
    expect_st("lat_e1", 3'd0);
    tick(1);
    expect_st("lat_e2", 3'd0);
    tick(1);
    expect_st("lat_pwdn", 3'd1);

    // 2: nominal run
    run_seq("nom");

    // drop from DONE
    pwr_en = 1'b0;
    tick(2);
    expect_st("drop_done_e2", 3'd4);
    tick(1);
    expect_st("drop_done", 3'd0);

    // 3: drop in SETTLE at cnt 10, then re-request
    pwr_en = 1'b1;
    tick(3);
    expect_st("req2", 3'd1);
    tick(18);
    expect_st("settle10", 3'd3);
    check_cnt("settle10_cnt", 5'd10);
    pwr_en = 1'b0;
    tick(2);
    expect_st("drop_settle_e2", 3'd3);
    tick(1);
    expect_st("drop_settle", 3'd0);
    check_cnt("drop_settle_cnt", 5'd0);
    pwr_en = 1'b1;
    tick(3);
    expect_st("req3", 3'd1);
    run_seq("rerun");

    // 4: drop lands on the PWDN expiry edge
    pwr_en = 1'b0;
    tick(3);
    expect_st("off4", 3'd0);
    pwr_en = 1'b1;
    tick(3);
    expect_st("req4", 3'd1);
    tick(3);
    pwr_en = 1'b0;
    tick(2);
    expect_st("pre_expiry", 3'd1);
    check_cnt("pre_expiry_cnt", 5'd5);
    tick(1);
    expect_st("expiry_drop", 3'd0);
    tick(3);
    expect_st("expiry_hold", 3'd0);

    // 5: async reset in the middle of RST
    pwr_en = 1'b1;
    tick(3);
    expect_st("req5", 3'd1);
    tick(7);
    expect_st("in_rst", 3'd2);
    check_cnt("in_rst_cnt", 5'd1);
    #2;
    sys_rst = 1'b1;
    #1;
    expect_st("async_rst", 3'd0);
    check_cnt("async_rst_cnt", 5'd0);
    tick(2);
    expect_st("async_rst_hold", 3'd0);
    sys_rst = 1'b0;
    tick(2);
    expect_st("rel5_e2", 3'd0);
    tick(1);
    expect_st("rel5_pwdn", 3'd1);
    run_seq("after_rst");

    // 6: illegal code recovery, then long DONE hold
    #2;
    force dut.state_q = 3'd6;
    #1;
    release dut.state_q;
    tick(1);
    expect_st("illegal", 3'd0);
    tick(1);
    expect_st("recover_pwdn", 3'd1);
    run_seq("recover");

    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      tick(1);
      if (observed() !== vec(3'd4) || dut.cnt_q !== 5'd0)
        bad++;
    end
    n_tests++;
    assert (bad == 0) else begin
      n_fail++;
      $error("FAIL done_hold: %0d unstable edges, expected 0", bad);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
